// File: rtl/conv1_window_fetcher.sv
// conv1_window_fetcher: streams every 5x5 window of the 28x28 image in RAM to conv1, row-major.
// Latency: 27 cycles per window (25 reads, 1 drain, 1 hold); first win_valid 27 cycles after start.
// Backpressure: win_ready low parks the FSM in HOLD with win_* stable and no reads issued.
// Ports: clk/rst (sync, active-high); start = loader image_loaded pulse;
//   rd_en/rd_addr/rd_data = image RAM read port (1-cycle read latency);
//   win_data/win_valid/win_ready/win_row/win_col = window stream; busy/done = status.
module conv1_window_fetcher #(
  parameter int IMG_W  = 28,
  parameter int K      = 5,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [7:0]         rd_data,
  output logic [K*K*8-1:0]   win_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [4:0]         win_row,
  output logic [4:0]         win_col,
  output logic               busy,
  output logic               done
);

  localparam int OUT_W  = IMG_W - K + 1;
  localparam int SLOT_W = $clog2(K*K);
  localparam int KW     = $clog2(K);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HOLD, FIN} state_t;

  state_t              state;
  logic [KW-1:0]       kx;
  logic [KW-1:0]       ky;
  logic [SLOT_W-1:0]   rd_slot;   // slot of the read currently on rd_addr
  logic [SLOT_W-1:0]   cap_slot;  // slot whose data is on rd_data this cycle
  logic                cap_vld;
  logic [ADDR_W-1:0]   base;      // address of window's top-left pixel: row*IMG_W + col

  logic last_tap;
  logic last_col;
  logic last_win;

  assign last_tap = (kx == KW'(K-1)) && (ky == KW'(K-1));
  assign last_col = (win_col == 5'(OUT_W-1));
  assign last_win = last_col && (win_row == 5'(OUT_W-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      win_data  <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      kx        <= '0;
      ky        <= '0;
      rd_slot   <= '0;
      cap_slot  <= '0;
      cap_vld   <= 1'b0;
      base      <= '0;
    end else begin
      done     <= 1'b0;
      // Slot index travels one cycle behind the read to match RAM latency.
      cap_vld  <= rd_en;
      cap_slot <= rd_slot;
      if (cap_vld) begin
        for (int s = 0; s < K*K; s++) begin
          if (cap_slot == SLOT_W'(s)) win_data[8*s +: 8] <= rd_data;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            base    <= '0;
            kx      <= '0;
            ky      <= '0;
            rd_slot <= '0;
            win_row <= '0;
            win_col <= '0;
          end
        end

        FETCH: begin
          if (last_tap) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_slot <= rd_slot + SLOT_W'(1);
            if (kx == KW'(K-1)) begin
              // Jump from the end of one kernel row to the start of the next image row.
              kx      <= '0;
              ky      <= ky + KW'(1);
              rd_addr <= rd_addr + ADDR_W'(IMG_W - K + 1);
            end else begin
              kx      <= kx + KW'(1);
              rd_addr <= rd_addr + ADDR_W'(1);
            end
          end
        end

        DRAIN: begin
          state     <= HOLD;
          win_valid <= 1'b1;
        end

        HOLD: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (last_win) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= FETCH;
              rd_en   <= 1'b1;
              kx      <= '0;
              ky      <= '0;
              rd_slot <= '0;
              if (last_col) begin
                // (row, OUT_W-1) -> (row+1, 0): base advances by IMG_W-OUT_W+1 = K.
                win_col <= '0;
                win_row <= win_row + 5'd1;
                base    <= base + ADDR_W'(K);
                rd_addr <= base + ADDR_W'(K);
              end else begin
                win_col <= win_col + 5'd1;
                base    <= base + ADDR_W'(1);
                rd_addr <= base + ADDR_W'(1);
              end
            end
          end
        end

        FIN: begin
          state   <= IDLE;
          busy    <= 1'b0;
          win_row <= '0;
          win_col <= '0;
          rd_addr <= '0;
          base    <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1_window_fetcher.sv
// tb_conv1_window_fetcher: directed checks of the window fetcher against a RAM holding a mod 256.
// Latency: n/a (bench).
// Backpressure: exercises a 10-cycle win_ready stall at window (0,1).
module tb_conv1_window_fetcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         rd_en;
  logic [9:0]   rd_addr;
  logic [7:0]   rd_data;
  logic [199:0] win_data;
  logic         win_valid;
  logic         win_ready;
  logic [4:0]   win_row;
  logic [4:0]   win_col;
  logic         busy;
  logic         done;

  logic [7:0]   mem [1024];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  conv1_window_fetcher dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Image RAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int           first_valid;
  int           hs;
  int           done_cyc;
  int           overlap;
  int           busy_at_done;
  int           unstable;
  int           bad_cnt;
  logic [199:0] snap;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = a[7:0];
    rd_data = 8'd0;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_data_zero", (win_data == '0), 1);

    // ---------------- full sweep + window (0,0) + start while busy ----------------
    start = 1'b1;
    cyc = 0;
    first_valid = -1;
    hs = 0;
    done_cyc = -1;
    overlap = 0;
    busy_at_done = 0;
    while (cyc < 16000 && done_cyc < 0) begin
      step();
      start = (cyc == 100);
      if (cyc == 1) begin
        chk("c1_rd_en", rd_en, 1);
        chk("c1_rd_addr", rd_addr, 0);
        chk("c1_busy", busy, 1);
      end
      if (win_valid && rd_en) overlap++;
      if (win_valid && first_valid < 0) begin
        first_valid = cyc;
        chk("w00_row", win_row, 0);
        chk("w00_col", win_col, 0);
        for (int s = 0; s < 5; s++) chk("w00_slot_r0", win_data[8*s +: 8], s);
        for (int s = 5; s < 10; s++) chk("w00_slot_r1", win_data[8*s +: 8], 28 + s - 5);
        chk("w00_slot24", win_data[199:192], 116);
      end
      if (win_valid && win_row == 5'd23 && win_col == 5'd23) begin
        chk("w2323_slot0", win_data[7:0], 155);
        chk("w2323_slot12", win_data[103:96], 213);
        chk("w2323_slot24", win_data[199:192], 15);
      end
      if (win_valid && win_ready) hs++;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
    chk("first_valid_cyc", first_valid, 27);
    chk("handshakes", hs, 576);
    chk("done_cyc", done_cyc, 15553);
    chk("busy_in_fin", busy_at_done, 1);
    chk("valid_during_read", overlap, 0);
    step();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);

    // ---------------- backpressure at window (0,1) ----------------
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (cyc < 28) begin
      step();
      start = 1'b0;
    end
    win_ready = 1'b0;
    while (!win_valid && cyc < 200) step();
    chk("bp_valid_cyc", cyc, 54);
    chk("bp_col", win_col, 1);
    chk("bp_slot0", win_data[7:0], 1);
    chk("bp_slot24", win_data[199:192], 117);
    snap = win_data;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (!win_valid || win_data !== snap || win_col != 5'd1 || win_row != 5'd0 || rd_en)
        unstable++;
      step();
    end
    chk("bp_stable_cycles", unstable, 0);
    win_ready = 1'b1;
    chk("bp_still_valid", win_valid, 1);
    step();
    chk("bp_next_rd_en", rd_en, 1);
    chk("bp_next_rd_addr", rd_addr, 2);
    chk("bp_valid_dropped", win_valid, 0);
    chk("bp_next_col", win_col, 2);

    // ---------------- reset mid-fetch ----------------
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_rd_en", rd_en, 0);
    chk("mr_rd_addr", rd_addr, 0);
    chk("mr_busy", busy, 0);
    chk("mr_win_valid", win_valid, 0);
    chk("mr_win_rowcol", {win_row, win_col}, 0);
    chk("mr_done", done, 0);
    chk("mr_win_data_zero", (win_data == '0), 1);
    while (cyc < 50) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (!win_valid && cyc < 300) step();
    chk("mr_valid_cyc", cyc, 77);
    chk("mr_row", win_row, 0);
    chk("mr_col", win_col, 0);
    chk("mr_slot24", win_data[199:192], 116);
    chk("mr_slot6", win_data[55:48], 29);

    // ---------------- reset/start collision ----------------
    do_reset();
    rst = 1'b1;
    start = 1'b1;
    bad_cnt = 0;
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy || rd_en) bad_cnt++;
      step();
    end
    chk("collision_busy_or_rd", bad_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1_window_fetcher.md
# conv1_window_fetcher

Reads the 28×28 8-bit image that the UART image loader writes into image RAM and presents it to the conv1 datapath as 5×5 windows, one for each of the 24×24 valid output positions, in row-major order. The fetch starts on the loader's one-cycle `image_loaded` pulse and uses a valid/ready handshake toward conv1. It finishes with a `done` pulse once the final window has been accepted.

## Interface
Parameters:
- `IMG_W`, default 28: image width and height in pixels.
- `K`, default 5: kernel size.
- `OUT_W`, derived localparam `IMG_W-K+1` (24): window positions per row and per column.
- `ADDR_W`, default 10: image RAM address width.

Ports:
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: connects to the loader's `image_loaded` pulse.
- `rd_en` output, 1 bit: image RAM read enable.
- `rd_addr` output, `ADDR_W` bits: image RAM read address.
- `rd_data` input, 8 bits: RAM read data, valid exactly 1 cycle after `rd_en`.
- `win_data` output, `K*K*8` (200) bits: current window. Slot s = ky*K+kx occupies bits [8s+7:8s].
- `win_valid` output, 1 bit: window is valid.
- `win_ready` input, 1 bit: consumer accepts the window.
- `win_row` output, 5 bits: output-row index of the presented window.
- `win_col` output, 5 bits: output-column index of the presented window.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse after the final window has been accepted.

## Operation
- FSM states are IDLE, FETCH, DRAIN, HOLD, FIN.
- IDLE:
  - `start`=1 clears row, col, ky and kx to 0 and moves to FETCH.
  - `start` in any other state is ignored.
- FETCH:
  - `rd_en`=1 every cycle.
  - `rd_addr = (row+ky)*IMG_W + (col+kx)`.
  - kx increments 0→4; on wrap, kx returns to 0 and ky increments.
  - After the read with ky=4, kx=4 (25 reads), the FSM moves to DRAIN.
- Capture: in every cycle following a read, `rd_data` is written into the slot of that read. A delayed slot index is carried alongside the read for this purpose.
- DRAIN:
  - `rd_en`=0.
  - Captures slot 24.
  - Moves to HOLD.
- HOLD:
  - `win_valid`=1.
  - `win_data`, `win_row` and `win_col` are held stable until `win_ready`=1.
  - On handshake (`win_valid` & `win_ready`) where it is not the last window: col increments. If col was 23, col goes to 0 and row increments. The FSM then goes to FETCH.
  - On handshake at row=23, col=23: the FSM goes to FIN.
- FIN:
  - `done`=1 for one cycle.
  - Moves to IDLE.
  - row, col, `win_row` and `win_col` return to 0.
- `win_row`/`win_col` always equal the row/col of the window being fetched or held.
- Address arithmetic: maximum address is 783, so it fits in 10 bits. The address is computed with adds and shifts or with incremental base counters. No multiplier is instantiated.
- The RAM is never written by this block. The host must not send the next image until `done` has pulsed, and the block does not check for this.

## Timing
- Reset values: `rd_en`, `rd_addr`, `win_data`, `win_valid`, `win_row`, `win_col`, `busy` and `done` are all 0. State is IDLE.
- `rst` during any state:
  - The FSM returns to IDLE on the next edge.
  - Any in-flight read data is discarded.
  - No `done` pulse is produced.
- `rst` and `start` high together: `rst` wins and the block stays in IDLE.
- Cycle numbering: call the cycle with `start` high cycle 0. Then:
  - Reads occur in cycles 1–25.
  - DRAIN is cycle 26.
  - `win_valid` first rises in cycle 27.
- Per-window cost with `win_ready` tied high: 27 cycles (25 FETCH, 1 DRAIN, 1 HOLD).
- With `win_ready` tied high, `done` is high in cycle 576*27+1 = 15553.
- `win_ready` low extends HOLD indefinitely. No read is issued while in HOLD.
- `win_valid` drops in the cycle after the handshake. `win_valid` is never high in FETCH, DRAIN, FIN or IDLE.
- `busy` rises in cycle 1, is high in FIN, and is low again in the cycle after `done`.

## Test plan
- **Window (0,0).** Preload RAM[a] = a mod 256, pulse `start`. Required response:
  - First `win_valid` in cycle 27 with `win_row`=0, `win_col`=0.
  - Slots 0–4 = 0..4.
  - Slots 5–9 = 28..32.
  - Slot 24 = 116.
- **Full sweep.** Same preload, `win_ready`=1. Required response:
  - Exactly 576 handshakes.
  - Window (23,23) slot 24 = 783 mod 256 = 15 and slot 0 = 667 mod 256 = 155.
  - `done` single-cycle in cycle 15553, then `busy`=0.
- **Backpressure.** Hold `win_ready`=0 for 10 cycles at window (0,1). Required response:
  - `win_valid`, `win_data` and `win_col`=1 are stable throughout.
  - `rd_en`=0 throughout.
  - The next window starts reading 1 cycle after the handshake.
- **Start while busy.** Pulse `start` again at cycle 100. Required response: no change to the sequence, and `done` still in cycle 15553.
- **Reset mid-fetch.** Assert `rst` at cycle 40 for 1 cycle, then pulse `start` at cycle 50. Required response:
  - All outputs are 0 at cycle 41.
  - The sweep restarts at window (0,0).
  - `win_valid` rises at cycle 77.
- **Reset/start collision.** Assert `rst` and `start` together. Required response: `busy` stays 0 and `rd_en` is never asserted.
